// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver states and counter-width helper.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Receiver-to-consumer word interface with per-word status flags.
interface uart_rx_os_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun, busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun, busy,
    output rx_ready
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator; one-cycle tick every DIV clocks.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned RATE  = BAUD * OVERSAMPLE;
  localparam int unsigned DIV   = (CLK_HZ + RATE / 2) / RATE;
  localparam int unsigned DIV_W = cnt_width(DIV);

  if (DIV < 2) begin : g_div_chk
    $error("uart_baud_tick: clock too slow for BAUD*OVERSAMPLE (DIV < 2)");
  end

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q;

  always_comb begin
    cnt_d = (cnt_q == DIV_W'(DIV - 1)) ? '0 : cnt_q + DIV_W'(1);
  end

  // Tick is registered so it coincides with the counter sitting at DIV-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == DIV_W'(DIV - 1));
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: synchroniser, 3-sample majority vote, deframing FSM
// and a valid/ready output stage with parity/frame/overrun flags.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          RxD,
  uart_rx_os_if.master  rx
);

  localparam int unsigned OS_W  = cnt_width(OVERSAMPLE);
  localparam int unsigned BIT_W = cnt_width(DATA_BITS);

  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_os_chk
    $error("uart_rx_os: OVERSAMPLE must be even and >= 4");
  end

  logic tick;

  uart_baud_tick #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  rx_state_e            state_q, state_d;
  logic                 sync1_q, sync2_q;
  logic                 prev_q, prev_d;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [1:0]           votes_q, votes_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q, busy_d;

  logic rxd_s, maj_c, exp_par_c, last_tick_c, vote_tick_c, done_c, accept_c;

  assign rxd_s       = sync2_q;
  assign maj_c       = (votes_q[0] & votes_q[1]) | (votes_q[0] & rxd_s) | (votes_q[1] & rxd_s);
  assign exp_par_c   = (PARITY == PARITY_ODD) ? ~(^shift_q) : ^shift_q;
  assign last_tick_c = (os_cnt_q == OS_W'(OVERSAMPLE - 1));
  assign vote_tick_c = (os_cnt_q == OS_W'(OVERSAMPLE / 2 + 1));
  assign accept_c    = valid_q & rx.rx_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RX_IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      votes_q   <= '0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= RxD;
      sync2_q   <= sync1_q;
      prev_q    <= prev_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      votes_q   <= votes_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
      ovr_q     <= ovr_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    votes_d   = votes_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    done_c    = 1'b0;

    if (tick) begin
      prev_d = rxd_s;
      if (state_q == RX_IDLE) begin
        // Only a real high-to-low transition starts a frame; a held-low line does not.
        if (prev_q && !rxd_s) begin
          state_d   = RX_START;
          os_cnt_d  = '0;
          bit_cnt_d = '0;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
        end
      end else begin
        os_cnt_d = last_tick_c ? '0 : os_cnt_q + OS_W'(1);
        if (os_cnt_q == OS_W'(OVERSAMPLE / 2 - 1)) votes_d[0] = rxd_s;
        if (os_cnt_q == OS_W'(OVERSAMPLE / 2))     votes_d[1] = rxd_s;

        unique case (state_q)
          RX_START: begin
            if (vote_tick_c && maj_c) state_d = RX_IDLE;
            else if (last_tick_c)     state_d = RX_DATA;
          end
          RX_DATA: begin
            if (vote_tick_c) shift_d = {maj_c, shift_q[DATA_BITS-1:1]};
            if (last_tick_c) begin
              if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                bit_cnt_d = '0;
                state_d   = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
              end else begin
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
              end
            end
          end
          RX_PARITY: begin
            if (vote_tick_c) perr_d = (maj_c != exp_par_c);
            if (last_tick_c) state_d = RX_STOP;
          end
          RX_STOP: begin
            // Finish at the last stop bit's mid-sample so an early next start is caught.
            if (vote_tick_c) begin
              if (!maj_c) ferr_d = 1'b1;
              if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
                state_d = RX_IDLE;
                done_c  = 1'b1;
              end
            end else if (last_tick_c) begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end
          default: state_d = RX_IDLE;
        endcase
      end
    end
  end

  // Output stage: deliver, or drop and flag overrun while a word is still pending.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    ovr_d   = ovr_q;
    busy_d  = (state_d != RX_IDLE);

    if (accept_c) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (done_c) begin
      if (!valid_q || accept_c) begin
        data_d  = shift_q;
        pe_d    = perr_q;
        fe_d    = ferr_d;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign rx.rx_data    = data_q;
  assign rx.rx_valid   = valid_q;
  assign rx.parity_err = pe_q;
  assign rx.frame_err  = fe_q;
  assign rx.overrun    = ovr_q;
  assign rx.busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench: three receivers (8N1, 8E1, 8N2) on separate lines, random and directed frames.
module tb_uart_rx_os;

  localparam int unsigned CLK_HZ  = 1_600_000;
  localparam int unsigned BAUD    = 10_000;
  localparam int unsigned OS      = 16;
  localparam int unsigned NB      = 8;
  localparam int unsigned BIT_CLK = 160;

  function automatic int unsigned par_of(input int d);
    return (d == 1) ? 1 : 0;
  endfunction

  function automatic int unsigned stops_of(input int d);
    return (d == 2) ? 2 : 1;
  endfunction

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [2:0] rxd, ready;
  logic [2:0] valid_w, busy_w, perr_w, ferr_w, ovr_w;
  logic [2:0][7:0] data_w;

  exp_t exp_q [3][$];
  int   checks = 0;
  int   errors = 0;
  int   n_rx [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_rx_os_if #(.DATA_BITS(NB)) bus ();
    assign bus.rx_ready = ready[g];
    assign valid_w[g]   = bus.rx_valid;
    assign busy_w[g]    = bus.busy;
    assign perr_w[g]    = bus.parity_err;
    assign ferr_w[g]    = bus.frame_err;
    assign ovr_w[g]     = bus.overrun;
    assign data_w[g]    = bus.rx_data;

    uart_rx_os #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .OVERSAMPLE (OS),
      .DATA_BITS  (NB),
      .PARITY     (par_of(g)),
      .STOP_BITS  (stops_of(g))
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .RxD   (rxd[g]),
      .rx    (bus)
    );
  end

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h, required %0h", name, d, act, req);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake pops the oldest expected word for that receiver.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!reset && valid_w[d] && ready[d]) begin
        n_rx[d]++;
        if (exp_q[d].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame dut%0d: got data %02h, required no frame", d, data_w[d]);
        end else begin
          exp_t e;
          e = exp_q[d].pop_front();
          chk("rx_data", d, 32'(data_w[d]), 32'(e.data));
          chk("parity_err", d, 32'(perr_w[d]), 32'(e.perr));
          chk("frame_err", d, 32'(ferr_w[d]), 32'(e.ferr));
        end
      end
    end
  end

  // Frame model: start 0, data LSB first, optional even parity, stop bits (forced low where asked).
  task automatic send(input int d, input logic [7:0] data, input bit bad_par,
                      input logic [1:0] stop_low, input bit glitch, input bit push);
    logic bits [$];
    logic pbit;
    exp_t e;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    pbit = (^data) ^ bad_par;
    if (par_of(d) != 0) bits.push_back(pbit);
    e.data = data;
    e.perr = (par_of(d) != 0) && (pbit != (^data));
    e.ferr = 1'b0;
    for (int s = 0; s < int'(stops_of(d)); s++) begin
      bits.push_back(!stop_low[s]);
      if (stop_low[s]) e.ferr = 1'b1;
    end
    if (push) exp_q[d].push_back(e);
    foreach (bits[i]) begin
      rxd[d] = bits[i];
      if (glitch && i >= 1 && i <= 8) begin
        int off;
        off = int'($urandom_range(60, 110));
        wait_clk(off);
        rxd[d] = !bits[i];
        wait_clk(1);
        rxd[d] = bits[i];
        wait_clk(int'(BIT_CLK) - off - 1);
      end else begin
        wait_clk(BIT_CLK);
      end
    end
    rxd[d] = 1'b1;
    wait_clk(BIT_CLK);
  endtask

  initial begin
    int base;
    reset = 1'b1;
    rxd   = 3'b111;
    ready = 3'b111;
    @(posedge clk);
    #1;
    wait_clk(3);
    for (int d = 0; d < 3; d++) begin
      chk("reset_valid", d, 32'(valid_w[d]), 0);
      chk("reset_data", d, 32'(data_w[d]), 0);
      chk("reset_flags", d, {29'd0, perr_w[d], ferr_w[d], ovr_w[d]}, 0);
      chk("reset_busy", d, 32'(busy_w[d]), 0);
    end
    reset = 1'b0;
    wait_clk(2 * BIT_CLK);

    // 8N1 0xA5: exactly one 1-cycle valid pulse
    base = n_rx[0];
    send(0, 8'hA5, 1'b0, 2'b00, 1'b0, 1'b1);
    chk("a5_one_pulse", 0, 32'(n_rx[0] - base), 1);
    chk("a5_valid_low", 0, 32'(valid_w[0]), 0);

    // 8E1 parity wrong then right
    send(1, 8'h3C, 1'b1, 2'b00, 1'b0, 1'b1);
    send(1, 8'h3C, 1'b0, 2'b00, 1'b0, 1'b1);

    // 8N2 second stop low
    send(2, 8'h55, 1'b0, 2'b10, 1'b0, 1'b1);

    // Break on 8N2 line: one zero frame with frame error, no retrigger while low
    base = n_rx[2];
    exp_q[2].push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b1});
    rxd[2] = 1'b0;
    wait_clk(25 * BIT_CLK);
    chk("break_busy_low", 2, 32'(busy_w[2]), 0);
    wait_clk(5 * BIT_CLK);
    rxd[2] = 1'b1;
    wait_clk(3 * BIT_CLK);
    chk("break_one_frame", 2, 32'(n_rx[2] - base), 1);

    // Overrun: second frame dropped while first is pending
    ready[0] = 1'b0;
    send(0, 8'h11, 1'b0, 2'b00, 1'b0, 1'b1);
    send(0, 8'h22, 1'b0, 2'b00, 1'b0, 1'b0);
    chk("ovr_valid", 0, 32'(valid_w[0]), 1);
    chk("ovr_data", 0, 32'(data_w[0]), 32'h11);
    chk("ovr_flag", 0, 32'(ovr_w[0]), 1);
    ready[0] = 1'b1;
    wait_clk(2);
    chk("ovr_cleared", 0, 32'(ovr_w[0]), 0);
    chk("ovr_valid_low", 0, 32'(valid_w[0]), 0);

    // 40-clk glitch on idle line: false start, nothing reported
    base = n_rx[0];
    rxd[0] = 1'b0;
    wait_clk(30);
    chk("glitch_busy_hi", 0, 32'(busy_w[0]), 1);
    wait_clk(10);
    rxd[0] = 1'b1;
    wait_clk(BIT_CLK);
    chk("glitch_busy_low", 0, 32'(busy_w[0]), 0);
    chk("glitch_no_frame", 0, 32'(n_rx[0] - base), 0);

    // 1-clk glitches inside data bits are outvoted
    send(0, 8'h96, 1'b0, 2'b00, 1'b1, 1'b1);
    send(1, 8'h4B, 1'b0, 2'b00, 1'b1, 1'b1);

    // Reset during bit 4 of 0xFF, then 0x81
    rxd[0] = 1'b0;
    wait_clk(BIT_CLK);
    rxd[0] = 1'b1;
    wait_clk(4 * BIT_CLK + BIT_CLK / 2);
    reset = 1'b1;
    wait_clk(3);
    chk("rst_mid_busy", 0, 32'(busy_w[0]), 0);
    chk("rst_mid_valid", 0, 32'(valid_w[0]), 0);
    reset = 1'b0;
    wait_clk(2 * BIT_CLK);
    send(0, 8'h81, 1'b0, 2'b00, 1'b0, 1'b1);

    // Random frames across all three formats
    for (int i = 0; i < 15; i++) begin
      int d;
      logic [1:0] sl;
      d  = int'($urandom_range(0, 2));
      sl = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (stops_of(d) == 1) sl[1] = 1'b0;
      send(d, 8'($urandom), (d == 1) && ($urandom_range(0, 3) == 0), sl,
           1'($urandom_range(0, 1)), 1'b1);
    end

    for (int t = 0; t < 5 * int'(BIT_CLK); t++) begin
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) break;
      wait_clk(1);
    end
    for (int d = 0; d < 3; d++) chk("pending_frames", d, 32'(exp_q[d].size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
